// File: rtl/cve2_rf_wb_arbiter_if.sv
// Write-port arbiter bus: execute/LSU write requests, decode read hazards, register file write port.
// Forward data signals exist only when CVE2_WB_FWD_EN is defined.
interface cve2_rf_wb_arbiter_if #(
  parameter int unsigned DataWidth = 32
);
  logic                 ex_valid_i;
  logic                 ex_ready_o;
  logic [4:0]           ex_waddr_i;
  logic [DataWidth-1:0] ex_wdata_i;
  logic                 lsu_req_i;
  logic [4:0]           lsu_req_waddr_i;
  logic                 lsu_valid_i;
  logic [4:0]           lsu_waddr_i;
  logic [DataWidth-1:0] lsu_wdata_i;
  logic [4:0]           raddr_a_i;
  logic [4:0]           raddr_b_i;
  logic                 hazard_a_o;
  logic                 hazard_b_o;
  logic [4:0]           rf_waddr_o;
  logic [DataWidth-1:0] rf_wdata_o;
  logic                 rf_we_o;
  logic                 lsu_err_o;
  logic                 busy_o;
`ifdef CVE2_WB_FWD_EN
  logic [DataWidth-1:0] fwd_a_o;
  logic [DataWidth-1:0] fwd_b_o;
`endif

  modport slave (
    input  ex_valid_i, ex_waddr_i, ex_wdata_i,
    input  lsu_req_i, lsu_req_waddr_i, lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    input  raddr_a_i, raddr_b_i,
`ifdef CVE2_WB_FWD_EN
    output fwd_a_o, fwd_b_o,
`endif
    output ex_ready_o, hazard_a_o, hazard_b_o,
    output rf_waddr_o, rf_wdata_o, rf_we_o, lsu_err_o, busy_o
  );

  modport master (
    output ex_valid_i, ex_waddr_i, ex_wdata_i,
    output lsu_req_i, lsu_req_waddr_i, lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    output raddr_a_i, raddr_b_i,
`ifdef CVE2_WB_FWD_EN
    input  fwd_a_o, fwd_b_o,
`endif
    input  ex_ready_o, hazard_a_o, hazard_b_o,
    input  rf_waddr_o, rf_wdata_o, rf_we_o, lsu_err_o, busy_o
  );
endinterface

// File: rtl/cve2_rf_wb_arbiter.sv
// Register file write-port arbiter: LSU responses > buffered EX writes > direct EX write.
// Optional CVE2_WB_FWD_EN adds forwarding outputs and narrows hazards to pending loads.
module cve2_rf_wb_arbiter #(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned FifoDepth = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  cve2_rf_wb_arbiter_if.slave bus
);

  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW = $clog2(FifoDepth + 1);

  typedef enum logic [1:0] {
    SelNone,
    SelLsu,
    SelFifo,
    SelEx
  } sel_e;

  function automatic logic legal(input logic [4:0] a);
    return (a != 5'd0) && (!RV32E || !a[4]);
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (32'(p) == FifoDepth - 1) ? '0 : p + 1'b1;
  endfunction

  logic [4:0]           fifo_addr [FifoDepth];
  logic [DataWidth-1:0] fifo_data [FifoDepth];
  logic [FifoDepth-1:0] fifo_vld;
  logic [PtrW-1:0]      rd_ptr;
  logic [PtrW-1:0]      wr_ptr;
  logic [CntW-1:0]      count;
  logic [31:0]          pending;

  logic                 rf_we;
  logic [4:0]           rf_waddr;
  logic [DataWidth-1:0] rf_wdata;
  logic                 lsu_err;

  logic                 ex_ready;
  logic                 ex_acc;
  logic                 ex_live;
  logic                 lsu_live;
  logic                 fifo_empty;
  sel_e                 sel;
  logic                 push;
  logic                 pop;
  logic [4:0]           sel_addr;
  logic [DataWidth-1:0] sel_data;

  assign fifo_empty = (count == '0);
  assign ex_ready   = (count < CntW'(FifoDepth)) && !pending[bus.ex_waddr_i];
  assign ex_acc     = bus.ex_valid_i && ex_ready;
  assign ex_live    = ex_acc && legal(bus.ex_waddr_i);
  assign lsu_live   = bus.lsu_valid_i && legal(bus.lsu_waddr_i);

  // Illegal-address writes are not candidates, so they never take the port from a legal one.
  always_comb begin
    sel      = SelNone;
    sel_addr = '0;
    sel_data = '0;
    if (lsu_live) begin
      sel      = SelLsu;
      sel_addr = bus.lsu_waddr_i;
      sel_data = bus.lsu_wdata_i;
    end else if (!fifo_empty) begin
      sel      = SelFifo;
      sel_addr = fifo_addr[rd_ptr];
      sel_data = fifo_data[rd_ptr];
    end else if (ex_live) begin
      sel      = SelEx;
      sel_addr = bus.ex_waddr_i;
      sel_data = bus.ex_wdata_i;
    end
  end

  assign pop  = (sel == SelFifo);
  assign push = ex_live && (sel != SelEx);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fifo_vld <= '0;
    end else begin
      if (pop) begin
        fifo_vld[rd_ptr] <= 1'b0;
        rd_ptr           <= ptr_inc(rd_ptr);
      end
      if (push) begin
        fifo_vld[wr_ptr] <= 1'b1;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.ex_waddr_i;
      fifo_data[wr_ptr] <= bus.ex_wdata_i;
    end
  end

  // Clear first, then set, so an issue and a response to the same register leave it pending.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending <= '0;
    end else begin
      logic [31:0] nxt;
      nxt = pending;
      if (bus.lsu_valid_i) nxt[bus.lsu_waddr_i] = 1'b0;
      if (bus.lsu_req_i && legal(bus.lsu_req_waddr_i)) nxt[bus.lsu_req_waddr_i] = 1'b1;
      pending <= nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      lsu_err  <= 1'b0;
    end else begin
      rf_we    <= (sel != SelNone);
      rf_waddr <= sel_addr;
      rf_wdata <= sel_data;
      lsu_err  <= lsu_live && !pending[bus.lsu_waddr_i];
    end
  end

  logic fifo_hit_a;
  logic fifo_hit_b;
  logic [DataWidth-1:0] fifo_fwd_a;
  logic [DataWidth-1:0] fifo_fwd_b;

  // Valid slots are contiguous from rd_ptr, so walking from there makes the last hit the youngest.
  always_comb begin
    int unsigned idx;
    fifo_hit_a = 1'b0;
    fifo_hit_b = 1'b0;
    fifo_fwd_a = '0;
    fifo_fwd_b = '0;
    for (int unsigned k = 0; k < FifoDepth; k++) begin
      idx = (32'(rd_ptr) + k) % FifoDepth;
      if (fifo_vld[PtrW'(idx)] && fifo_addr[PtrW'(idx)] == bus.raddr_a_i) begin
        fifo_hit_a = 1'b1;
        fifo_fwd_a = fifo_data[PtrW'(idx)];
      end
      if (fifo_vld[PtrW'(idx)] && fifo_addr[PtrW'(idx)] == bus.raddr_b_i) begin
        fifo_hit_b = 1'b1;
        fifo_fwd_b = fifo_data[PtrW'(idx)];
      end
    end
  end

  logic ex_hit_a;
  logic ex_hit_b;
  logic out_hit_a;
  logic out_hit_b;

  assign ex_hit_a  = ex_live && (bus.ex_waddr_i == bus.raddr_a_i);
  assign ex_hit_b  = ex_live && (bus.ex_waddr_i == bus.raddr_b_i);
  assign out_hit_a = rf_we && (rf_waddr == bus.raddr_a_i);
  assign out_hit_b = rf_we && (rf_waddr == bus.raddr_b_i);

`ifdef CVE2_WB_FWD_EN
  always_comb begin
    bus.fwd_a_o = '0;
    if (ex_hit_a)        bus.fwd_a_o = bus.ex_wdata_i;
    else if (fifo_hit_a) bus.fwd_a_o = fifo_fwd_a;
    else if (out_hit_a)  bus.fwd_a_o = rf_wdata;
  end

  always_comb begin
    bus.fwd_b_o = '0;
    if (ex_hit_b)        bus.fwd_b_o = bus.ex_wdata_i;
    else if (fifo_hit_b) bus.fwd_b_o = fifo_fwd_b;
    else if (out_hit_b)  bus.fwd_b_o = rf_wdata;
  end

  assign bus.hazard_a_o = legal(bus.raddr_a_i) && pending[bus.raddr_a_i];
  assign bus.hazard_b_o = legal(bus.raddr_b_i) && pending[bus.raddr_b_i];
`else
  logic unused_fwd;
  assign unused_fwd = ^{fifo_fwd_a, fifo_fwd_b};

  assign bus.hazard_a_o = legal(bus.raddr_a_i) &&
                          (pending[bus.raddr_a_i] || fifo_hit_a || out_hit_a || ex_hit_a);
  assign bus.hazard_b_o = legal(bus.raddr_b_i) &&
                          (pending[bus.raddr_b_i] || fifo_hit_b || out_hit_b || ex_hit_b);
`endif

  assign bus.ex_ready_o = ex_ready;
  assign bus.rf_we_o    = rf_we;
  assign bus.rf_waddr_o = rf_waddr;
  assign bus.rf_wdata_o = rf_wdata;
  assign bus.lsu_err_o  = lsu_err;
  assign bus.busy_o     = !fifo_empty || (pending != '0) || rf_we;

endmodule

// File: tb/tb_cve2_rf_wb_arbiter.sv
// Directed bench for cve2_rf_wb_arbiter: default build plus an RV32E instance.
module tb_cve2_rf_wb_arbiter;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cve2_rf_wb_arbiter_if #(.DataWidth(32)) bus ();
  cve2_rf_wb_arbiter_if #(.DataWidth(32)) bus_e ();

  cve2_rf_wb_arbiter #(.RV32E(1'b0), .DataWidth(32), .FifoDepth(2)) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  cve2_rf_wb_arbiter #(.RV32E(1'b1), .DataWidth(32), .FifoDepth(2)) dut_e (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus_e)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rf(input string tag, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we"}, 64'(bus.rf_we_o), 64'd1);
    chk({tag, "_waddr"}, 64'(bus.rf_waddr_o), 64'(a));
    chk({tag, "_wdata"}, 64'(bus.rf_wdata_o), 64'(d));
  endtask

  task automatic ex_drive(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.ex_valid_i = v;
    bus.ex_waddr_i = a;
    bus.ex_wdata_i = d;
  endtask

  task automatic lsu_drive(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.lsu_valid_i = v;
    bus.lsu_waddr_i = a;
    bus.lsu_wdata_i = d;
  endtask

  initial begin
    ex_drive(1'b0, 5'd0, 32'd0);
    lsu_drive(1'b0, 5'd0, 32'd0);
    bus.lsu_req_i = 1'b0;       bus.lsu_req_waddr_i = 5'd0;
    bus.raddr_a_i = 5'd0;       bus.raddr_b_i = 5'd0;
    bus_e.ex_valid_i = 1'b0;    bus_e.ex_waddr_i = 5'd0;   bus_e.ex_wdata_i = 32'd0;
    bus_e.lsu_req_i = 1'b0;     bus_e.lsu_req_waddr_i = 5'd0;
    bus_e.lsu_valid_i = 1'b0;   bus_e.lsu_waddr_i = 5'd0;  bus_e.lsu_wdata_i = 32'd0;
    bus_e.raddr_a_i = 5'd0;     bus_e.raddr_b_i = 5'd0;

    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    #1;
    chk("rst_we", 64'(bus.rf_we_o), 64'd0);
    chk("rst_waddr", 64'(bus.rf_waddr_o), 64'd0);
    chk("rst_wdata", 64'(bus.rf_wdata_o), 64'd0);
    chk("rst_err", 64'(bus.lsu_err_o), 64'd0);
    chk("rst_ready", 64'(bus.ex_ready_o), 64'd1);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_haz_a", 64'(bus.hazard_a_o), 64'd0);
    chk("rst_haz_b", 64'(bus.hazard_b_o), 64'd0);
    chk("rst_e_we", 64'(bus_e.rf_we_o), 64'd0);

    // Direct EX write with empty FIFO
    @(negedge clk);
    ex_drive(1'b1, 5'd5, 32'hDEADBEEF);
    bus.raddr_a_i = 5'd5;
    #1;
    chk("dir_ready", 64'(bus.ex_ready_o), 64'd1);
    chk("dir_haz_ex", 64'(bus.hazard_a_o), 64'd1);
    @(negedge clk);
    chk_rf("dir", 5'd5, 32'hDEADBEEF);
    ex_drive(1'b0, 5'd0, 32'd0);
    #1;
`ifndef CVE2_WB_FWD_EN
    chk("dir_haz_out", 64'(bus.hazard_a_o), 64'd1);
`else
    chk("dir_fwd_out", 64'(bus.fwd_a_o), 64'hDEADBEEF);
`endif
    chk("dir_busy", 64'(bus.busy_o), 64'd1);
    @(negedge clk);
    chk("dir_idle_we", 64'(bus.rf_we_o), 64'd0);
    chk("dir_idle_haz", 64'(bus.hazard_a_o), 64'd0);
    chk("dir_idle_busy", 64'(bus.busy_o), 64'd0);

    // Two loads outstanding, their responses collide with three EX writes
    bus.lsu_req_i = 1'b1; bus.lsu_req_waddr_i = 5'd7; bus.raddr_b_i = 5'd7;
    @(negedge clk);
    bus.lsu_req_waddr_i = 5'd8;
    #1;
    chk("pend_haz_b", 64'(bus.hazard_b_o), 64'd1);
    chk("pend_busy", 64'(bus.busy_o), 64'd1);
    @(negedge clk);
    bus.lsu_req_i = 1'b0;
    ex_drive(1'b1, 5'd1, 32'h101);
    lsu_drive(1'b1, 5'd7, 32'h11);
    #1;
    chk("q_ready0", 64'(bus.ex_ready_o), 64'd1);
    @(negedge clk);
    chk_rf("q_x7", 5'd7, 32'h11);
    ex_drive(1'b1, 5'd2, 32'h102);
    lsu_drive(1'b1, 5'd8, 32'h22);
    #1;
    chk("q_ready1", 64'(bus.ex_ready_o), 64'd1);
    @(negedge clk);
    chk_rf("q_x8", 5'd8, 32'h22);
    ex_drive(1'b1, 5'd3, 32'hAB);
    lsu_drive(1'b0, 5'd0, 32'd0);
    #1;
    chk("q_full_ready", 64'(bus.ex_ready_o), 64'd0);
    @(negedge clk);
    chk_rf("q_x1", 5'd1, 32'h101);
    #1;
    chk("q_ready_again", 64'(bus.ex_ready_o), 64'd1);
    @(negedge clk);
    chk_rf("q_x2", 5'd2, 32'h102);
    ex_drive(1'b0, 5'd0, 32'd0);
    bus.raddr_a_i = 5'd3;
    #1;
`ifndef CVE2_WB_FWD_EN
    chk("q_haz_fifo", 64'(bus.hazard_a_o), 64'd1);
`else
    chk("q_fwd_haz", 64'(bus.hazard_a_o), 64'd0);
    chk("q_fwd_fifo", 64'(bus.fwd_a_o), 64'hAB);
`endif
    chk("q_haz_b_clear", 64'(bus.hazard_b_o), 64'd0);
    @(negedge clk);
    chk_rf("q_x3", 5'd3, 32'hAB);
    @(negedge clk);
    chk("q_done_we", 64'(bus.rf_we_o), 64'd0);
    chk("q_done_busy", 64'(bus.busy_o), 64'd0);

    // WAW stall behind an outstanding load
    bus.lsu_req_i = 1'b1; bus.lsu_req_waddr_i = 5'd9; bus.raddr_a_i = 5'd9;
    @(negedge clk);
    bus.lsu_req_i = 1'b0;
    ex_drive(1'b1, 5'd9, 32'h99);
    #1;
    chk("waw_ready0", 64'(bus.ex_ready_o), 64'd0);
    chk("waw_haz", 64'(bus.hazard_a_o), 64'd1);
    @(negedge clk);
    chk("waw_no_we", 64'(bus.rf_we_o), 64'd0);
    lsu_drive(1'b1, 5'd9, 32'h90);
    #1;
    chk("waw_ready1", 64'(bus.ex_ready_o), 64'd0);
    @(negedge clk);
    chk_rf("waw_lsu", 5'd9, 32'h90);
    chk("waw_err", 64'(bus.lsu_err_o), 64'd0);
    lsu_drive(1'b0, 5'd0, 32'd0);
    #1;
    chk("waw_ready2", 64'(bus.ex_ready_o), 64'd1);
    @(negedge clk);
    chk_rf("waw_ex", 5'd9, 32'h99);
    ex_drive(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("waw_idle", 64'(bus.rf_we_o), 64'd0);

    // Illegal addresses: x0 here, x20 on the RV32E instance
    ex_drive(1'b1, 5'd0, 32'h1);
    lsu_drive(1'b1, 5'd0, 32'h2);
    bus.raddr_a_i = 5'd0;
    bus_e.ex_valid_i = 1'b1; bus_e.ex_waddr_i = 5'd20; bus_e.ex_wdata_i = 32'h20;
    bus_e.lsu_req_i = 1'b1;  bus_e.lsu_req_waddr_i = 5'd20; bus_e.raddr_a_i = 5'd20;
    #1;
    chk("x0_ready", 64'(bus.ex_ready_o), 64'd1);
    chk("x0_haz", 64'(bus.hazard_a_o), 64'd0);
    chk("e20_ready", 64'(bus_e.ex_ready_o), 64'd1);
    chk("e20_haz", 64'(bus_e.hazard_a_o), 64'd0);
    @(negedge clk);
    chk("x0_we", 64'(bus.rf_we_o), 64'd0);
    chk("x0_err", 64'(bus.lsu_err_o), 64'd0);
    chk("x0_busy", 64'(bus.busy_o), 64'd0);
    chk("e20_we", 64'(bus_e.rf_we_o), 64'd0);
    chk("e20_busy", 64'(bus_e.busy_o), 64'd0);
    ex_drive(1'b0, 5'd0, 32'd0);
    lsu_drive(1'b0, 5'd0, 32'd0);
    bus_e.lsu_req_i = 1'b0;
    bus_e.ex_waddr_i = 5'd15; bus_e.ex_wdata_i = 32'h15;
    @(negedge clk);
    chk("e15_we", 64'(bus_e.rf_we_o), 64'd1);
    chk("e15_waddr", 64'(bus_e.rf_waddr_o), 64'd15);
    bus_e.ex_valid_i = 1'b0;

    // Response without a pending load
    lsu_drive(1'b1, 5'd4, 32'h44);
    @(negedge clk);
    chk_rf("err_x4", 5'd4, 32'h44);
    chk("err_pulse", 64'(bus.lsu_err_o), 64'd1);
    lsu_drive(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("err_clear", 64'(bus.lsu_err_o), 64'd0);

    // Same-cycle issue and response to x6: set wins
    bus.lsu_req_i = 1'b1; bus.lsu_req_waddr_i = 5'd6; bus.raddr_b_i = 5'd6;
    lsu_drive(1'b1, 5'd6, 32'h66);
    @(negedge clk);
    chk("sw_err", 64'(bus.lsu_err_o), 64'd1);
    chk("sw_wdata", 64'(bus.rf_wdata_o), 64'h66);
    bus.lsu_req_i = 1'b0;
    lsu_drive(1'b0, 5'd0, 32'd0);
    #1;
    chk("sw_pending", 64'(bus.hazard_b_o), 64'd1);
    lsu_drive(1'b1, 5'd6, 32'h67);
    @(negedge clk);
    chk("sw_err2", 64'(bus.lsu_err_o), 64'd0);
    chk("sw_wdata2", 64'(bus.rf_wdata_o), 64'h67);
    lsu_drive(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("sw_haz_clear", 64'(bus.hazard_b_o), 64'd0);

    // Reset with a buffered write and an output-stage write in flight
    bus.lsu_req_i = 1'b1; bus.lsu_req_waddr_i = 5'd12;
    @(negedge clk);
    bus.lsu_req_i = 1'b0;
    lsu_drive(1'b1, 5'd12, 32'hC);
    ex_drive(1'b1, 5'd11, 32'hB);
    @(negedge clk);
    lsu_drive(1'b0, 5'd0, 32'd0);
    ex_drive(1'b0, 5'd0, 32'd0);
    bus.raddr_a_i = 5'd11;
    chk_rf("mr_x12", 5'd12, 32'hC);
    chk("mr_busy", 64'(bus.busy_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("mr_we", 64'(bus.rf_we_o), 64'd0);
    chk("mr_wdata", 64'(bus.rf_wdata_o), 64'd0);
    chk("mr_busy0", 64'(bus.busy_o), 64'd0);
    chk("mr_haz", 64'(bus.hazard_a_o), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("mr_no_stale_we", 64'(bus.rf_we_o), 64'd0);
    chk("mr_no_stale_busy", 64'(bus.busy_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
